// File: rtl/cma_ctrl_pkg.sv
// Shared definitions for the CMA job sequencer: state encoding and default widths.
package cma_ctrl_pkg;

  localparam int DATA_W_D     = 32;
  localparam int EXA_W_D      = 16;
  localparam int ROMULTIC_W_D = 2;
  localparam int CNT_W_D      = 16;
  localparam int TMO_W_D      = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5
  } cma_state_e;

endpackage

// File: rtl/cma_rd_fifo2.sv
// Two-entry valid/ready buffer for CMA readback words, with occupancy output.
module cma_rd_fifo2
  import cma_ctrl_pkg::*;
#(
  parameter int W = DATA_W_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);

  logic [W-1:0] slot0, slot1;
  logic         rd_ptr, wr_ptr;
  logic         pop, do_push;

  assign out_valid = (occ != 2'd0);
  assign out_data  = rd_ptr ? slot1 : slot0;
  assign pop       = out_valid && out_ready;
  // when full, a same-cycle pop frees the slot the write pointer points at
  assign do_push   = push && ((occ != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0  <= '0;
      slot1  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) slot1 <= push_data;
        else        slot0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(do_push) - 2'(pop);
    end
  end

endmodule

// File: rtl/cma_job_ctrl.sv
// Host-side sequencer for one CMA job: load words, run, wait for done, drain results.
// Optional done-wait timeout is enabled by defining CMA_JOB_TMO_EN.
module cma_job_ctrl
  import cma_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int EXA_W      = EXA_W_D,
  parameter int ROMULTIC_W = ROMULTIC_W_D,
  parameter int CNT_W      = CNT_W_D,
  parameter int TMO_W      = TMO_W_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [EXA_W-1:0]      cfg_wbase,
  input  logic [CNT_W-1:0]      cfg_nwr,
  input  logic [EXA_W-1:0]      cfg_rbase,
  input  logic [CNT_W-1:0]      cfg_nrd,
  input  logic                  cfg_bank,
  input  logic [ROMULTIC_W-1:0] cfg_romul,
  input  logic [TMO_W-1:0]      cfg_tmo,
  output logic                  busy,
  output logic                  job_done,
  output logic                  err_tmo,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  cbank,
  output logic                  run,
  output logic                  exwe,
  output logic                  exre,
  output logic [EXA_W-1:0]      exa,
  output logic [DATA_W-1:0]     exwd,
  output logic [ROMULTIC_W-1:0] exromul,
  input  logic [DATA_W-1:0]     exrd,
  input  logic                  done
);

  // state | meaning
  // IDLE  | waiting for start, CMA outputs quiet
  // LOAD  | streaming in_data words into CMA memory
  // RUN   | one cycle, raises run
  // WAIT  | run high, waiting for done (or timeout)
  // DRAIN | reading result words out through the 2-entry buffer
  // FIN   | job_done pulse
  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_RUN   = ST_RUN;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_FIN   = ST_FIN;

  logic [2:0]            state, state_nxt;
  logic [EXA_W-1:0]      wr_addr, rd_addr;
  logic [CNT_W-1:0]      wr_left, rd_left, acc_left;
  logic [ROMULTIC_W-1:0] romul_q;
  logic                  bank_q;
  logic                  cap_q;
  logic [1:0]            occ;
  logic                  issue, pop, tmo_hit, busy_nxt;

  assign busy     = (state == S_LOAD) || (state == S_RUN) || (state == S_WAIT) || (state == S_DRAIN);
  assign job_done = (state == S_FIN);
  assign in_ready = (state == S_LOAD);
  assign pop      = out_valid && out_ready;

  // a read is outstanding from exre until its word lands in the buffer (cap_q)
  assign issue = (state == S_DRAIN) && (rd_left != '0) &&
                 (({1'b0, occ} + {2'b0, exre} + {2'b0, cap_q}) < 3'd2);

`ifdef CMA_JOB_TMO_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (state == S_WAIT) && !done && (tmo_cnt <= TMO_W'(1));
  assign err_tmo = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        tmo_cnt <= cfg_tmo;
        err_q   <= 1'b0;
      end else begin
        if (state == S_WAIT && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
        if (tmo_hit) err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_tmo;
  assign tmo_hit    = 1'b0;
  assign err_tmo    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (cfg_nwr == '0) ? S_RUN : S_LOAD;
      S_LOAD:  if (in_valid && wr_left == CNT_W'(1)) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (done)         state_nxt = (acc_left == '0) ? S_FIN : S_DRAIN;
        else if (tmo_hit) state_nxt = S_FIN;
      end
      S_DRAIN: if (pop && acc_left == CNT_W'(1)) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_RUN) ||
                    (state_nxt == S_WAIT) || (state_nxt == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_left  <= '0;
      rd_left  <= '0;
      acc_left <= '0;
      romul_q  <= '0;
      bank_q   <= 1'b0;
      cap_q    <= 1'b0;
      cbank    <= 1'b0;
      run      <= 1'b0;
      exwe     <= 1'b0;
      exre     <= 1'b0;
      exa      <= '0;
      exwd     <= '0;
      exromul  <= '0;
    end else begin
      state   <= state_nxt;
      exwe    <= 1'b0;
      exre    <= issue;
      cap_q   <= exre;
      exa     <= '0;
      exwd    <= '0;
      exromul <= '0;
      cbank   <= busy_nxt ? ((state == S_IDLE) ? cfg_bank : bank_q) : 1'b0;
      case (state)
        S_IDLE: if (start) begin
          wr_addr  <= cfg_wbase;
          rd_addr  <= cfg_rbase;
          wr_left  <= cfg_nwr;
          rd_left  <= cfg_nrd;
          acc_left <= cfg_nrd;
          romul_q  <= cfg_romul;
          bank_q   <= cfg_bank;
        end
        S_LOAD: if (in_valid) begin
          exwe    <= 1'b1;
          exwd    <= in_data;
          exa     <= wr_addr;
          exromul <= romul_q;
          wr_addr <= wr_addr + EXA_W'(1);
          wr_left <= wr_left - CNT_W'(1);
        end
        S_RUN:  run <= 1'b1;
        S_WAIT: if (done || tmo_hit) run <= 1'b0;
        S_DRAIN: begin
          if (issue) begin
            exa     <= rd_addr;
            rd_addr <= rd_addr + EXA_W'(1);
            rd_left <= rd_left - CNT_W'(1);
          end
          if (pop) acc_left <= acc_left - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  cma_rd_fifo2 #(.W(DATA_W)) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cap_q),
    .push_data (exrd),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
  );

endmodule

// File: tb/tb_cma_job_ctrl.sv
// Self-checking bench for cma_job_ctrl with a behavioural CMA memory model.
module tb_cma_job_ctrl;

  logic        clk, rst_n, start;
  logic [15:0] cfg_wbase, cfg_rbase;
  logic [15:0] cfg_nwr, cfg_nrd;
  logic        cfg_bank;
  logic [1:0]  cfg_romul;
  logic [19:0] cfg_tmo;
  logic        busy, job_done, err_tmo;
  logic [31:0] in_data, out_data, exwd, exrd;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        cbank, run, exwe, exre, done;
  logic [15:0] exa;
  logic [1:0]  exromul;

  cma_job_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_wbase(cfg_wbase), .cfg_nwr(cfg_nwr), .cfg_rbase(cfg_rbase), .cfg_nrd(cfg_nrd),
    .cfg_bank(cfg_bank), .cfg_romul(cfg_romul), .cfg_tmo(cfg_tmo),
    .busy(busy), .job_done(job_done), .err_tmo(err_tmo),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cbank(cbank), .run(run), .exwe(exwe), .exre(exre), .exa(exa), .exwd(exwd),
    .exromul(exromul), .exrd(exrd), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] wbase; int nwr; logic [15:0] rbase; int nrd; int nout;
    logic bank; logic [1:0] romul; int dly; logic [19:0] tmo; bit stall; bit poke;
    int exp_run_cyc; int exp_last_wa; int exp_run_lat; int exp_jd_lat; logic exp_err; int seed;
  } vec_t;

  int errors = 0, checks = 0;
  logic [31:0] cmem [0:65535];
  logic [31:0] refm [0:65535];

  vec_t cur;
  bit   mon_en = 1'b0;
  int   nwe, nre, nacc, ndone, run_cyc, cyc, cyc_start, cyc_run1, cyc_done1, cyc_jd;
  int   bad_romul, bad_weare, bad_cbank, bad_busy, overissue;
  logic [15:0] last_wa;
  logic err_at_jd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wdat(input int seed, input int k);
    return 32'h5A00_0000 + 32'(seed) * 32'h0001_0000 + 32'(k) * 32'h0000_0101;
  endfunction

  // CMA memory model: write on exwe, read data valid the cycle after exre
  always @(posedge clk) begin
    if (exwe) cmem[exa] <= exwd;
    exrd <= exre ? cmem[exa] : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (start && !busy && cyc_start < 0) cyc_start = cyc;
      if (exwe) begin
        chk("wr_addr", exa, 16'(cur.wbase + 16'(nwe)));
        chk("wr_data", exwd, wdat(cur.seed, nwe));
        if (exromul !== cur.romul) bad_romul++;
        last_wa = exa;
        nwe++;
      end else if (exromul !== 2'd0) bad_romul++;
      if (exwe && exre) bad_weare++;
      if (exre) begin
        chk("rd_addr", exa, 16'(cur.rbase + 16'(nre)));
        nre++;
        if (nre - nacc > 2) overissue++;
      end
      if (out_valid && out_ready) begin
        chk("rd_data", out_data, refm[16'(cur.rbase + 16'(nacc))]);
        nacc++;
      end
      if (run) begin
        run_cyc++;
        if (cyc_run1 < 0) cyc_run1 = cyc;
      end
      if (done && run && cyc_done1 < 0) cyc_done1 = cyc;
      if (busy && cbank !== cur.bank) bad_cbank++;
      if (!busy && cbank !== 1'b0) bad_cbank++;
      if (job_done) begin
        ndone++;
        if (busy) bad_busy++;
        err_at_jd = err_tmo;
        if (cyc_jd < 0) cyc_jd = cyc;
      end
    end
  end

  task automatic run_job(input vec_t v);
    int c;
    for (int k = 0; k < v.nwr; k++) refm[16'(v.wbase + 16'(k))] = wdat(v.seed, k);
    cur = v;
    nwe = 0; nre = 0; nacc = 0; ndone = 0; run_cyc = 0; cyc = 0;
    cyc_start = -1; cyc_run1 = -1; cyc_done1 = -1; cyc_jd = -1;
    bad_romul = 0; bad_weare = 0; bad_cbank = 0; bad_busy = 0; overissue = 0;
    last_wa = '0; err_at_jd = 1'bx;
    @(posedge clk); #1;
    cfg_wbase = v.wbase; cfg_nwr = 16'(v.nwr); cfg_rbase = v.rbase; cfg_nrd = 16'(v.nrd);
    cfg_bank = v.bank; cfg_romul = v.romul; cfg_tmo = v.tmo;
    start = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      begin : feeder
        int k = 0, fc = 0;
        while (k < v.nwr && fc < 2000) begin
          @(posedge clk); #1;
          in_valid = v.stall ? (fc % 3 != 1) : 1'b1;
          in_data  = wdat(v.seed, k);
          fc++;
          @(negedge clk);
          if (in_valid && in_ready) k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin : reader
        logic [3:0] rpat = 4'b1001;
        int rc = 0;
        while (nacc < v.nout && rc < 2000) begin
          @(posedge clk); #1;
          out_ready = v.stall ? rpat[rc % 4] : 1'b1;
          rc++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      begin : poker
        if (v.poke) begin
          repeat (3) @(posedge clk);
          #1;
          cfg_wbase = 16'h0999; cfg_nwr = 16'd7; cfg_nrd = 16'd9; start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      begin : done_drv
        if (v.dly >= 0) begin
          int dc = 0;
          do begin
            @(negedge clk);
            dc++;
          end while (!run && dc < 3000);
          repeat (v.dly) @(posedge clk);
          #1;
          done = 1'b1;
          @(negedge clk);
          chk("run_at_done", run, 1'b1);
          @(negedge clk);
          chk("run_after_done", run, 1'b0);
          dc = 0;
          while (ndone == 0 && dc < 3000) begin
            @(negedge clk);
            dc++;
          end
          @(posedge clk); #1;
          done = 1'b0;
        end
      end
    join
    c = 0;
    while (ndone == 0 && c < 6000) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    chk("n_exwe", nwe, v.nwr);
    chk("n_exre", nre, v.nout);
    chk("n_out", nacc, v.nout);
    chk("n_job_done", ndone, 1);
    chk("run_cycles", run_cyc, v.exp_run_cyc);
    chk("ctl_violations", bad_romul + bad_weare + bad_cbank + bad_busy + overissue, 0);
    chk("err_tmo_at_done", err_at_jd, v.exp_err);
    chk("busy_after_job", busy, 1'b0);
    if (v.exp_last_wa >= 0) chk("last_wr_addr", last_wa, 16'(v.exp_last_wa));
    if (v.exp_run_lat >= 0) chk("start_to_run", cyc_run1 - cyc_start, v.exp_run_lat);
    if (v.exp_jd_lat >= 0)  chk("done_to_job_done", cyc_jd - cyc_done1, v.exp_jd_lat);
  endtask

  vec_t tbl [5];
  vec_t tv;

  initial begin
    int c, bad;
    for (int a = 0; a < 65536; a++) begin
      cmem[a] = 32'hC0DE_0000 | 32'(a);
      refm[a] = 32'hC0DE_0000 | 32'(a);
    end
    //        wbase     nwr rbase     nrd nout bank romul dly tmo        stl  poke run  lastwa lat jd err seed
    tbl[0] = '{16'h0010, 4, 16'h0020, 3, 3, 1'b1, 2'd2, 50, 20'hFFFFF, 1'b0, 1'b0, 51, 'h13, -1, -1, 1'b0, 0};
    tbl[1] = '{16'hFFFE, 3, 16'h0100, 2, 2, 1'b0, 2'd1, 5,  20'hFFFFF, 1'b1, 1'b0, 6,  'h0,  -1, -1, 1'b0, 1};
    tbl[2] = '{16'h0000, 0, 16'h0000, 0, 0, 1'b1, 2'd3, 3,  20'hFFFFF, 1'b0, 1'b0, 4,  -1,   2,  1,  1'b0, 2};
    tbl[3] = '{16'h0040, 5, 16'h0040, 5, 5, 1'b0, 2'd1, 2,  20'hFFFFF, 1'b1, 1'b1, 3,  'h44, -1, -1, 1'b0, 3};
    tbl[4] = '{16'h0000, 0, 16'h0030, 4, 4, 1'b1, 2'd2, 1,  20'hFFFFF, 1'b1, 1'b0, 2,  -1,   2,  -1, 1'b0, 4};

    rst_n = 1'b0; start = 1'b0; done = 1'b0;
    cfg_wbase = '0; cfg_nwr = '0; cfg_rbase = '0; cfg_nrd = '0;
    cfg_bank = 1'b0; cfg_romul = '0; cfg_tmo = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {busy, job_done, err_tmo, in_ready, out_valid, cbank, run, exwe, exre, exromul, exa}, 64'h0);
    chk("reset_data", {exwd, out_data}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_job(tbl[i]);

`ifdef CMA_JOB_TMO_EN
    tv = '{16'h0300, 2, 16'h0310, 3, 0, 1'b1, 2'd1, -1, 20'd100, 1'b0, 1'b0, 100, 'h301, -1, -1, 1'b1, 5};
    run_job(tv);
    chk("err_tmo_sticky", err_tmo, 1'b1);
    run_job(tbl[2]);
    chk("err_tmo_cleared", err_tmo, 1'b0);
`else
    @(posedge clk); #1;
    cfg_nwr = '0; cfg_nrd = '0; cfg_tmo = 20'd5; cfg_bank = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (150) @(negedge clk);
    chk("no_tmo_still_waiting", {busy, run, err_tmo}, 3'b110);
    @(posedge clk); #1;
    done = 1'b1;
    c = 0;
    while (!job_done && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("late_done_completes", job_done, 1'b1);
    @(posedge clk); #1;
    done = 1'b0;
`endif

    // reset in the middle of a stalled drain
    @(posedge clk); #1;
    cfg_wbase = '0; cfg_nwr = '0; cfg_rbase = 16'h0200; cfg_nrd = 16'd6;
    cfg_bank = 1'b1; cfg_romul = 2'd3; cfg_tmo = 20'hFFFFF; out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!run && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk); #1;
    done = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < 50);
    chk("drain_stalled", {busy, out_valid, cbank}, 3'b111);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("midjob_reset_ctl", {busy, job_done, err_tmo, in_ready, out_valid, cbank, run, exwe, exre, exromul, exa}, 64'h0);
    chk("midjob_reset_data", {exwd, out_data}, 64'h0);
    done = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || run || exre || exwe || out_valid || job_done) bad++;
    end
    chk("no_resume_after_reset", bad, 0);

    run_job(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
